// File: rtl/melody_player.sv
// Note-ROM sequencer: fetches 10-bit note words at a fixed tempo and drives a registered frequency word in Hz.
// Optional articulation gap (silence at the tail of each note) is enabled by defining MELODY_ARTIC_GAP_EN.
module melody_player #(
  parameter int unsigned BEAT_DIV   = 12_500_000,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned LOOP       = 1,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  output logic [31:0]       freq,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_PLAY, S_DONE} state_e;

  localparam int unsigned TICK_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(BEAT_DIV - 1);

  if (BEAT_DIV == 0 || GAP_CYCLES > 32'h7fff_ffff) begin : g_bad_cfg
    $error("melody_player: BEAT_DIV must be nonzero and GAP_CYCLES below 2^31");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         freq_q, freq_d;
  logic                done_q, done_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [3:0]          beat_q, beat_d;
  logic [3:0]          dur_q, dur_d;
  logic                note_end;
  logic                addr_last;
`ifdef MELODY_ARTIC_GAP_EN
  logic [31:0]         rem_q, rem_d;
  logic [31:0]         note_len;
  assign note_len = 32'(rom_data[9:6]) * BEAT_DIV;
`endif

  function automatic logic [31:0] note_hz(input logic [9:0] w);
    logic [8:0] base;
    base = '0;
    case (w[3:0])
      4'd0:    base = 9'd262;
      4'd1:    base = 9'd277;
      4'd2:    base = 9'd294;
      4'd3:    base = 9'd311;
      4'd4:    base = 9'd330;
      4'd5:    base = 9'd349;
      4'd6:    base = 9'd370;
      4'd7:    base = 9'd392;
      4'd8:    base = 9'd415;
      4'd9:    base = 9'd440;
      4'd10:   base = 9'd466;
      4'd11:   base = 9'd494;
      default: base = 9'd0;
    endcase
    return 32'(base) << w[5:4];
  endfunction

  assign note_end  = (state_q == S_PLAY) && (tick_q == TICK_MAX) && (beat_q == dur_q - 4'd1);
  assign addr_last = (addr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    freq_d  = freq_q;
    done_d  = done_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    dur_d   = dur_q;
`ifdef MELODY_ARTIC_GAP_EN
    rem_d   = rem_q;
`endif
    // Dropping enable aborts from any state and rewinds the song.
    if (!enable) begin
      state_d = S_IDLE;
      addr_d  = '0;
      freq_d  = '0;
      done_d  = 1'b0;
      tick_d  = '0;
      beat_d  = '0;
`ifdef MELODY_ARTIC_GAP_EN
      rem_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          freq_d  = '0;
          state_d = S_FETCH;
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          if (rom_data[9:6] != 4'd0) begin
            freq_d  = note_hz(rom_data);
            dur_d   = rom_data[9:6];
            tick_d  = '0;
            beat_d  = '0;
            state_d = S_PLAY;
`ifdef MELODY_ARTIC_GAP_EN
            rem_d   = note_len;
            if (note_len <= GAP_CYCLES) freq_d = '0;
`endif
          end else if (LOOP != 0) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            freq_d  = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_PLAY: begin
          if (note_end) begin
            tick_d = '0;
            beat_d = '0;
            // The last ROM slot ending a note counts as end-of-song.
            if (!addr_last) begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end else if (LOOP != 0) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              freq_d  = '0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            if (tick_q == TICK_MAX) begin
              tick_d = '0;
              beat_d = beat_q + 4'd1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
`ifdef MELODY_ARTIC_GAP_EN
            rem_d = rem_q - 32'd1;
            if (rem_q - 32'd1 <= GAP_CYCLES) freq_d = '0;
`endif
          end
        end
        S_DONE: begin
          freq_d = '0;
          done_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      freq_q  <= '0;
      done_q  <= 1'b0;
      tick_q  <= '0;
      beat_q  <= '0;
      dur_q   <= '0;
`ifdef MELODY_ARTIC_GAP_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      dur_q   <= dur_d;
`ifdef MELODY_ARTIC_GAP_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign rom_addr  = addr_q;
  assign freq      = freq_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player: a looping instance (a) and a one-shot instance (b) share one note ROM.
module tb_melody_player;
  localparam int BD = 4;
  localparam int AW = 3;
  localparam int GP = 2;
`ifdef MELODY_ARTIC_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_PLAY = 3'd3, ST_DONE = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [9:0]    data_a, data_b;
  logic [31:0]   freq_a, freq_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [2:0]    st_a, st_b;
  logic [9:0]    rom [8];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  // clock / synchronous ROM models
  always #5 clk = ~clk;
  always @(posedge clk) begin
    data_a <= rom[addr_a];
    data_b <= rom[addr_b];
  end

  melody_player #(.BEAT_DIV(BD), .ADDR_W(AW), .LOOP(1), .GAP_CYCLES(GP)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .rom_addr(addr_a), .rom_data(data_a),
    .freq(freq_a), .busy(busy_a), .done(done_a), .dbg_state(st_a));

  melody_player #(.BEAT_DIV(BD), .ADDR_W(AW), .LOOP(0), .GAP_CYCLES(GP)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .rom_addr(addr_b), .rom_data(data_b),
    .freq(freq_b), .busy(busy_b), .done(done_b), .dbg_state(st_b));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int n, input logic [31:0] f, input logic [AW-1:0] a);
    repeat (n) begin
      exp_q.push_back(f);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic load_song();
    for (int i = 0; i < 8; i++) rom[i] = 10'd0;
    rom[0] = {4'd2, 2'd1, 4'd9};   // A5 = 880 Hz, 2 ticks
    rom[1] = {4'd1, 2'd0, 4'd12};  // rest, 1 tick
    rom[2] = 10'd0;                // end of song
  endtask

  // Expected freq/address per cycle from enable through the end marker and into the replay of ROM[0].
  task automatic push_song(input bit with_replay);
    push(2, 0, 0);
    if (GAP_ON) begin
      push(6, 880, 0); push(2, 0, 0); push(2, 0, 1);
    end else begin
      push(8, 880, 0); push(2, 880, 1);
    end
    push(4, 0, 1);
    push(2, 0, 2);
    if (with_replay) begin
      push(2, 0, 0);
      if (GAP_ON) begin
        push(6, 880, 0); push(2, 0, 0);
      end else begin
        push(8, 880, 0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
    tick(3);
    n_checks++;
    if ({st_a, st_b} !== {ST_IDLE, ST_IDLE}) begin
      n_fail++; $display("FAIL reset_state: got a=%0d b=%0d want 0 0", st_a, st_b);
    end
    n_checks++;
    if ({addr_a, addr_b, freq_a, freq_b} !== '0) begin
      n_fail++; $display("FAIL reset_addr_freq: got %0d %0d %0d %0d want zeros", addr_a, addr_b, freq_a, freq_b);
    end
    n_checks++;
    if ({busy_a, busy_b, done_a, done_b} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy_a, busy_b, done_a, done_b});
    end
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    tick(2);
  endtask

  task automatic test_loop();
    logic [31:0] ef;
    logic [AW-1:0] ea;
    load_song();
    push_song(1'b1);
    en_a = 1'b1;
    for (int i = 1; exp_q.size() > 0; i++) begin
      tick(1);
      ef = exp_q.pop_front();
      ea = exp_addr_q.pop_front();
      n_checks++;
      if (freq_a !== ef) begin
        n_fail++; $display("FAIL loop_freq cyc %0d: got %0d want %0d", i, freq_a, ef);
      end
      n_checks++;
      if (addr_a !== ea) begin
        n_fail++; $display("FAIL loop_addr cyc %0d: got %0d want %0d", i, addr_a, ea);
      end
      n_checks++;
      if ({busy_a, done_a} !== 2'b10) begin
        n_fail++; $display("FAIL loop_busy_done cyc %0d: got %b want 10", i, {busy_a, done_a});
      end
    end
    en_a = 1'b0;
    tick(1);
    n_checks++;
    if ({st_a, addr_a, freq_a, busy_a} !== {ST_IDLE, 3'd0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL loop_stop: got st=%0d addr=%0d freq=%0d busy=%b want 0 0 0 0", st_a, addr_a, freq_a, busy_a);
    end
    tick(1);
  endtask

  task automatic test_oneshot();
    logic [31:0] ef;
    logic [AW-1:0] ea;
    load_song();
    push_song(1'b0);
    en_b = 1'b1;
    for (int i = 1; exp_q.size() > 0; i++) begin
      tick(1);
      ef = exp_q.pop_front();
      ea = exp_addr_q.pop_front();
      n_checks++;
      if ({freq_b, addr_b, busy_b, done_b} !== {ef, ea, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL oneshot_play cyc %0d: got f=%0d a=%0d busy=%b done=%b want f=%0d a=%0d 1 0",
                           i, freq_b, addr_b, busy_b, done_b, ef, ea);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_checks++;
      if ({st_b, freq_b, busy_b, done_b} !== {ST_DONE, 32'd0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL oneshot_done hold %0d: got st=%0d f=%0d busy=%b done=%b want 4 0 0 1",
                           i, st_b, freq_b, busy_b, done_b);
      end
    end
    en_b = 1'b0;
    tick(1);
    n_checks++;
    if ({st_b, addr_b, done_b} !== {ST_IDLE, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL oneshot_clear: got st=%0d addr=%0d done=%b want 0 0 0", st_b, addr_b, done_b);
    end
    tick(1);
  endtask

  task automatic test_abort();
    load_song();
    en_a = 1'b1;
    tick(5);
    n_checks++;
    if ({st_a, freq_a} !== {ST_PLAY, 32'd880}) begin
      n_fail++; $display("FAIL abort_pre: got st=%0d f=%0d want 3 880", st_a, freq_a);
    end
    en_a = 1'b0;
    tick(1);
    n_checks++;
    if ({st_a, freq_a, addr_a} !== {ST_IDLE, 32'd0, 3'd0}) begin
      n_fail++; $display("FAIL abort_midnote: got st=%0d f=%0d a=%0d want 0 0 0", st_a, freq_a, addr_a);
    end
    en_a = 1'b1;
    tick(1);
    n_checks++;
    if ({st_a, addr_a} !== {ST_FETCH, 3'd0}) begin
      n_fail++; $display("FAIL abort_restart: got st=%0d a=%0d want 1 0", st_a, addr_a);
    end
    tick(2);
    n_checks++;
    if (freq_a !== 32'd880) begin
      n_fail++; $display("FAIL abort_replay: got f=%0d want 880", freq_a);
    end
    tick(8);
    n_checks++;
    if ({st_a, addr_a} !== {ST_FETCH, 3'd1}) begin
      n_fail++; $display("FAIL abort_pre2: got st=%0d a=%0d want 1 1", st_a, addr_a);
    end
    en_a = 1'b0;
    tick(1);
    n_checks++;
    if ({st_a, addr_a, freq_a} !== {ST_IDLE, 3'd0, 32'd0}) begin
      n_fail++; $display("FAIL abort_fetch: got st=%0d a=%0d f=%0d want 0 0 0", st_a, addr_a, freq_a);
    end
    tick(1);
  endtask

  task automatic test_wrap();
    logic [31:0] hz [8];
    logic [31:0] ef;
    logic [AW-1:0] ea;
    hz[0] = 262;  hz[1] = 554;  hz[2] = 1176; hz[3] = 2488;
    hz[4] = 330;  hz[5] = 698;  hz[6] = 1480; hz[7] = 3952;
    for (int i = 0; i < 7; i++) rom[i] = {4'd1, 2'(i), 4'(i)};
    rom[7] = {4'd1, 2'd3, 4'd11};
    push(2, 0, 0);
    for (int i = 0; i < 9; i++) begin
      if (GAP_ON) begin
        push(2, hz[i % 8], AW'(i)); push(2, 0, AW'(i));
      end else begin
        push(4, hz[i % 8], AW'(i));
      end
      if (i < 8) push(2, GAP_ON ? 32'd0 : hz[i], AW'((i + 1) % 8));
    end
    en_a = 1'b1;
    for (int i = 1; exp_q.size() > 0; i++) begin
      tick(1);
      ef = exp_q.pop_front();
      ea = exp_addr_q.pop_front();
      n_checks++;
      if ({freq_a, addr_a} !== {ef, ea}) begin
        n_fail++; $display("FAIL wrap cyc %0d: got f=%0d a=%0d want f=%0d a=%0d", i, freq_a, addr_a, ef, ea);
      end
    end
    n_checks++;
    if ({busy_a, done_a} !== 2'b10) begin
      n_fail++; $display("FAIL wrap_flags: got %b want 10", {busy_a, done_a});
    end
    en_a = 1'b0;
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 10'd0;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    test_reset();
    test_loop();
    test_oneshot();
    test_abort();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
